// File: rtl/stream_multiplexer_pkg.sv
// Shared definitions for the stream multiplexer: mode constants, channel limit,
// packet-lock state encoding and the wrap-around index helper.
package stream_multiplexer_pkg;

  localparam int MODE_FIXED       = 0;
  localparam int MODE_ROUND_ROBIN = 1;
  localparam int CHANNELS_MAX     = 16;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_multiplexer_if.sv
// Bus bundle for the stream multiplexer: CHANNELS valid/ready producer streams in,
// one registered stream out. master = producers/consumer side, slave = multiplexer.
interface stream_multiplexer_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8
);
  localparam int SEL_BITS = $clog2(CHANNELS);

  logic [CHANNELS-1:0][WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_last;
  logic [CHANNELS-1:0]            in_ready;
  logic [SEL_BITS-1:0]            sel;
  logic [WIDTH-1:0]               out_data;
  logic                           out_valid;
  logic                           out_last;
  logic [SEL_BITS-1:0]            out_sel;
  logic                           out_ready;

  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sel
  );

  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sel
  );
endinterface

// File: rtl/stream_multiplexer_rr_priority_encoder.sv
// Round-robin priority encoder: first set request at or above start_i, wrapping
// from CHANNELS-1 back to 0.
module rr_priority_encoder #(
  parameter int  CHANNELS = 8,
  localparam int SEL_BITS = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_BITS-1:0] start_i,
  output logic                grant_valid_o,
  output logic [SEL_BITS-1:0] grant_index_o
);

  int idx;

  // NOTE: every always_comb output gets a default before any branch; otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_index_o = '0;
    idx           = 0;
    // Walk from the farthest offset down so the nearest request wins last.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(start_i) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (req_i[SEL_BITS'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_index_o = SEL_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_multiplexer.sv
// N-to-1 valid/ready stream multiplexer with a one-entry registered output stage.
// Define STREAM_MULTIPLEXER_PACKET_LOCK_EN to hold the grant for a whole packet.
module stream_multiplexer
  import stream_multiplexer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int MODE     = MODE_FIXED
) (
  input logic                 clock,
  input logic                 reset,
  stream_multiplexer_if.slave bus
);

  localparam int SEL_BITS = $clog2(CHANNELS);

  if (CHANNELS < 2 || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("stream_multiplexer: CHANNELS must be within 2..16");
  end

  logic                base_valid;
  logic [SEL_BITS-1:0] base_idx;
  logic                grant_valid;
  logic [SEL_BITS-1:0] grant_idx;
  logic                stage_free;
  logic                accept_en;
  logic                xfer;
  logic                rr_advance;

  logic [WIDTH-1:0]    out_data_q;
  logic                out_last_q;
  logic [SEL_BITS-1:0] out_sel_q;
  logic                out_valid_q;

  assign stage_free = !out_valid_q || bus.out_ready;
  assign accept_en  = reset && stage_free && grant_valid;
  assign xfer       = accept_en && bus.in_valid[grant_idx];

  if (MODE == MODE_ROUND_ROBIN) begin : g_rr
    logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic                unused_sel;

    assign unused_sel = ^bus.sel;

    rr_priority_encoder #(.CHANNELS(CHANNELS)) u_encoder (
      .req_i         (bus.in_valid),
      .start_i       (rr_ptr_q),
      .grant_valid_o (base_valid),
      .grant_index_o (base_idx)
    );

    always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (rr_advance) rr_ptr_d = SEL_BITS'(next_index(int'(grant_idx), CHANNELS));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
    end
  end else begin : g_fixed
    logic unused_advance;

    assign unused_advance = rr_advance;
    assign base_valid     = 32'(bus.sel) < CHANNELS;
    assign base_idx       = bus.sel;
  end

`ifdef STREAM_MULTIPLEXER_PACKET_LOCK_EN
  lock_state_e         lock_state_q, lock_state_d;
  logic [SEL_BITS-1:0] lock_ch_q, lock_ch_d;

  // A beat without in_last holds the grant; a last beat (even the first) frees it.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_ch_d    = lock_ch_q;
    if (xfer) begin
      lock_ch_d    = grant_idx;
      lock_state_d = bus.in_last[grant_idx] ? LOCK_IDLE : LOCK_HELD;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_state_q <= LOCK_IDLE;
      lock_ch_q    <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_ch_q    <= lock_ch_d;
    end
  end

  assign grant_valid = (lock_state_q == LOCK_HELD) || base_valid;
  assign grant_idx   = (lock_state_q == LOCK_HELD) ? lock_ch_q : base_idx;
  assign rr_advance  = xfer && bus.in_last[grant_idx];
`else
  assign grant_valid = base_valid;
  assign grant_idx   = base_idx;
  assign rr_advance  = xfer;
`endif

  always_comb begin
    bus.in_ready = '0;
    if (accept_en) bus.in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_data_q  <= bus.in_data[grant_idx];
      out_last_q  <= bus.in_last[grant_idx];
      out_sel_q   <= grant_idx;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/stream_multiplexer.md
# stream_multiplexer

Parametrised successor to the fixed 8-way combinational multiplexer: selects one of `CHANNELS` valid/ready input streams of `WIDTH` bits and forwards it through a one-entry registered output stage. Selection is either by an external `sel` (fixed mode) or by a fair round-robin arbiter. It sits between multiple producers (e.g. load/store, fetch and debug request sources) and a single shared consumer port in the rvsimple datapath.

## Interface
Parameters:
- `WIDTH`, 32, data width of every channel and of the output
- `CHANNELS`, 8, number of input streams, 2..16
- `MODE`, 0, 0 = fixed select from `sel`; 1 = round-robin arbitration (`sel` ignored)

Ports (one clock; reset is asynchronous and active-low):
- `clock`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `in_data`  input  CHANNELS×WIDTH  per-channel payload
- `in_valid`  input  CHANNELS  per-channel valid
- `in_last`  input  CHANNELS  per-channel end-of-packet marker
- `in_ready`  output  CHANNELS  per-channel ready; a beat transfers when valid && ready
- `sel`  input  SEL_BITS = $clog2(CHANNELS)  channel index, fixed mode only
- `out_data`  output  WIDTH  registered payload
- `out_valid`  output  1  registered valid
- `out_last`  output  1  registered end-of-packet
- `out_sel`  output  SEL_BITS  index of the channel that produced the current output beat
- `out_ready`  input  1  consumer ready

## Operation
- Grant: fixed mode grants channel `sel` if `sel < CHANNELS`, else no grant. Round-robin grants the first channel with `in_valid` set, searching upward from pointer `rr_ptr` with wrap at `CHANNELS-1 → 0`.
- Output stage empty or draining (`!out_valid || out_ready`): `in_ready[g] = 1` for granted channel g only; all other `in_ready` = 0. Never more than one `in_ready` high.
- On transfer: register `out_data`/`out_last` from channel g, `out_sel = g`, `out_valid = 1`.
- `out_ready && out_valid` with no new transfer: `out_valid` → 0; data/sel/last hold their values.
- Output stage full and `out_ready = 0`: all `in_ready` = 0; outputs hold stable.
- `rr_ptr` update (round-robin only): after each transfer, `rr_ptr = (g + 1) mod CHANNELS`; unchanged otherwise.
- No valid channel: no grant, no pointer movement.

## Timing
- Latency: input beat to `out_valid` = 1 cycle. Throughput: 1 beat/cycle when `out_ready` stays high.
- `in_ready` is combinational from `in_valid`, `sel`, `rr_ptr`, lock state, `out_valid`, `out_ready`; no combinational path from any `in_data` to outputs.
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `out_sel` 0, `rr_ptr` 0, lock cleared; `in_ready` forced to 0 while `reset` is low.
- Reset mid-packet: in-flight beat discarded, lock released; first post-reset grant starts from channel 0.
- Simultaneous request by all channels in round-robin mode: strict rotation, each channel served once per `CHANNELS` transfers.

## Configuration
- `STREAM_MULTIPLEXER_PACKET_LOCK_EN` defined: grant is locked to channel g from its first transfer until a transfer with `in_last[g] = 1`; `sel` changes and other requests are ignored while locked; `rr_ptr` advances only on the last beat. A single-beat packet (`in_last` on the first beat) does not lock.
- Not defined: arbitration per beat; `in_last` is passed to `out_last` but has no effect on grant.

## Structure
- Shared package `stream_multiplexer_pkg`: `MODE_FIXED = 0`, `MODE_ROUND_ROBIN = 1` constants, `CHANNELS_MAX = 16`.
- Sub-module `rr_priority_encoder` (`CHANNELS`): inputs request vector and start pointer; outputs `grant_valid` and `grant_index`. Used only in round-robin mode.

## Test plan
- Fixed mode, CHANNELS=8, `sel=5`, only ch5 valid with 0xA5A5_0005, `out_ready=1` → next cycle `out_valid=1`, `out_data=0xA5A5_0005`, `out_sel=5`; `in_ready` = 8'b0010_0000.
- Round-robin, all 8 valid continuously, `out_ready=1` → `out_sel` sequence 0,1,2,…,7,0 over 9 cycles.
- Backpressure: `out_ready=0` for 3 cycles with output full → all `in_ready=0`, `out_data` unchanged; release → beat accepted, next beat 1 cycle later.
- Lock enabled, round-robin: ch2 sends 3-beat packet (last on beat 3) while ch3 valid → `out_sel` = 2,2,2,3; without macro → 2,3,….
- Fixed mode, CHANNELS=6, `sel=7` with all valid → no `in_ready`, `out_valid` stays 0.
- Assert `reset` low mid-packet with `out_valid=1` → immediately all outputs 0, `in_ready=0`; after release, round-robin first grant is lowest valid index ≥ 0.
